id_ex_hazard_stage: RTL
=======================

Name: id_ex_hazard_stage

Overview:
Parametrised ID/EX pipeline register for the RISC-V PPU. It extends the combinational control-zeroing mux into a registered stage. The stage performs load-use hazard detection, multi-cycle bubble insertion with an upstream stall output, flush, and downstream hold. It also has an N-source operand forwarding select with youngest-source priority, registered into EX.

Parameters:
CTRL_W, 29, width of packed control bundle (load, rf_en, ram_en, ram_rw, ram_se, jalr, jal, auipc, alu_op[4], shift_imm[3], ram_size[2], reg_amount[2], opfunct[10])
DATA_W, 32, operand width
NUM_SRC, 3, number of forwarding sources (index 0 = youngest, e.g. EX/MEM)
STALL_CYCLES, 1, bubbles inserted per load-use hazard (>=1)
LOAD_BIT, 28, index of the load-instruction flag inside the ctrl bundle

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  ID holds a real instruction
in_ctrl  in  CTRL_W  control bundle from the control unit
in_rs1, in_rs2  in  5  source register indices
in_rd  in  5  destination index
in_op_a, in_op_b  in  DATA_W  register-file read data
fwd_we  in  NUM_SRC  forwarding source i writes a register
fwd_rd  in  NUM_SRC*5  dest of source i at [i*5 +: 5]
fwd_data  in  NUM_SRC*DATA_W  value of source i at [i*DATA_W +: DATA_W]
flush  in  1  squash instruction entering EX (branch/jump taken)
hold  in  1  downstream freeze, stage retains contents
stall_o  out  1  freeze PC and IF/ID this cycle
out_valid  out  1  EX holds a real instruction
out_ctrl  out  CTRL_W  registered control bundle
out_rd  out  5  registered destination
out_op_a, out_op_b  out  DATA_W  registered, forwarded operands

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_ctrl=0, out_rd=0, out_op_a=0, out_op_b=0, state=RUN, counter=0. stall_o=0 while in reset. The stage resumes in RUN on the first edge after release. Reset mid-stall abandons the stall.
- Hazard (combinational): haz = in_valid & out_valid & out_ctrl[LOAD_BIT] & (out_rd!=0) & (out_rd==in_rs1 | out_rd==in_rs2).
- FSM states: RUN, STALL. Counter width is clog2(STALL_CYCLES+1).
- RUN, stall_o = haz & ~flush & ~hold.
- STALL, stall_o = 1 unless flush.
- Per-edge priority (highest first):
  1. flush: load bubble (out_valid=0, out_ctrl=0, out_rd=0, ops=0), state->RUN, counter=0.
  2. hold: all registers and FSM unchanged. stall_o follows the rules above.
  3. RUN & haz: load bubble. If STALL_CYCLES==1, stay in RUN; else state->STALL, counter=STALL_CYCLES-1.
  4. STALL: load bubble, counter-1. When counter reaches 1 at the edge, state->RUN.
  5. Otherwise capture: out_valid=in_valid. out_ctrl=in_valid?in_ctrl:0. out_rd=in_rd. out_op_a/b = forwarded values.
- Bubble duration: exactly STALL_CYCLES bubbles per hazard. stall_o is high for exactly STALL_CYCLES non-hold cycles. The ID instruction is captured on the following edge.
- Forwarding per operand (rs1→a, rs2→b): take the lowest index i with fwd_we[i] & fwd_rd[i]==rs & rs!=0, and use fwd_data[i]. If no match, use the RF value. x0 never forwards.
- Latency: one cycle from ID inputs to EX outputs.
- No X propagation: out_ctrl is forced to 0 whenever out_valid=0.

Decomposition:
- Shared package (ppu_pkg): CTRL_W, field offsets of the control bundle (LOAD_BIT and the others), REG_IDX_W=5, FSM state encoding.
- One sub-module: fwd_select. It is an N-source priority forwarding mux, parametrised by NUM_SRC/DATA_W, and instantiated twice (a and b).

Test Plan:
- Plain capture: in_valid=1, in_ctrl=29'h1ABCDEF, rd=5, op_a=7, no fwd, one edge -> out_valid=1, out_ctrl=29'h1ABCDEF, out_rd=5, out_op_a=7, stall_o=0 throughout.
- Load-use, STALL_CYCLES=1: EX holds a load to x3, ID has rs1=3 -> stall_o=1 for one cycle, one bubble (out_valid=0, out_ctrl=0). The next edge captures the ID instruction.
- Load-use, STALL_CYCLES=2: same stimulus -> stall_o high for 2 cycles, 2 bubbles, then capture. A hazard against rd=x0 produces no stall.
- Forwarding priority: rs1=4, fwd_we=3'b011, fwd_rd[0]=4 with data 100, fwd_rd[1]=4 with data 200, RF=50 -> out_op_a=100. With fwd_we=3'b010 -> 200. With rs1=0 and matching sources -> RF value 0.
- Flush during STALL (STALL_CYCLES=3, flush in 2nd stall cycle) -> bubble loaded, stall_o=0 that cycle, state RUN next edge. hold=1 for 2 cycles -> outputs frozen and the stall count is not consumed.
- Async reset: assert rst_n=0 mid-STALL between clock edges -> all outputs 0 immediately, stall_o=0. After release, a normal instruction is captured on the first edge.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared definitions for the PPU pipeline: control-bundle layout,
// register index width and the ID/EX hazard FSM state encoding.
package ppu_pkg;

  localparam int unsigned CTRL_W    = 29;
  localparam int unsigned REG_IDX_W = 5;

  // Control bundle layout, MSB first
  localparam int unsigned LOAD_BIT       = 28;
  localparam int unsigned RF_EN_BIT      = 27;
  localparam int unsigned RAM_EN_BIT     = 26;
  localparam int unsigned RAM_RW_BIT     = 25;
  localparam int unsigned RAM_SE_BIT     = 24;
  localparam int unsigned JALR_BIT       = 23;
  localparam int unsigned JAL_BIT        = 22;
  localparam int unsigned AUIPC_BIT      = 21;
  localparam int unsigned ALU_OP_LSB     = 17;
  localparam int unsigned ALU_OP_W       = 4;
  localparam int unsigned SHIFT_IMM_LSB  = 14;
  localparam int unsigned SHIFT_IMM_W    = 3;
  localparam int unsigned RAM_SIZE_LSB   = 12;
  localparam int unsigned RAM_SIZE_W     = 2;
  localparam int unsigned REG_AMOUNT_LSB = 10;
  localparam int unsigned REG_AMOUNT_W   = 2;
  localparam int unsigned OPFUNCT_LSB    = 0;
  localparam int unsigned OPFUNCT_W      = 10;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } stage_state_t;

endpackage

// File: rtl/fwd_select.sv
// N-source priority forwarding mux; source 0 is the youngest and wins.
// Register x0 never forwards.
module fwd_select #(
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned DATA_W  = 32
) (
  input  logic [ppu_pkg::REG_IDX_W-1:0]         rs,
  input  logic [DATA_W-1:0]                     rf_data,
  input  logic [NUM_SRC-1:0]                    fwd_we,
  input  logic [NUM_SRC*ppu_pkg::REG_IDX_W-1:0] fwd_rd,
  input  logic [NUM_SRC*DATA_W-1:0]             fwd_data,
  output logic [DATA_W-1:0]                     data
);
  import ppu_pkg::*;

  logic found;

  // Scan from youngest source; first match wins, else the RF value
  always_comb begin
    data  = rf_data;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!found && fwd_we[i] && (rs != '0) &&
          (fwd_rd[i*REG_IDX_W +: REG_IDX_W] == rs)) begin
        data  = fwd_data[i*DATA_W +: DATA_W];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection, multi-cycle
// bubble insertion (upstream stall), flush, downstream hold and
// registered operand forwarding.
module id_ex_hazard_stage #(
  parameter int unsigned CTRL_W       = ppu_pkg::CTRL_W,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned NUM_SRC      = 3,
  parameter int unsigned STALL_CYCLES = 1,
  parameter int unsigned LOAD_BIT     = ppu_pkg::LOAD_BIT
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  input  logic [CTRL_W-1:0]                     in_ctrl,
  input  logic [ppu_pkg::REG_IDX_W-1:0]         in_rs1,
  input  logic [ppu_pkg::REG_IDX_W-1:0]         in_rs2,
  input  logic [ppu_pkg::REG_IDX_W-1:0]         in_rd,
  input  logic [DATA_W-1:0]                     in_op_a,
  input  logic [DATA_W-1:0]                     in_op_b,
  input  logic [NUM_SRC-1:0]                    fwd_we,
  input  logic [NUM_SRC*ppu_pkg::REG_IDX_W-1:0] fwd_rd,
  input  logic [NUM_SRC*DATA_W-1:0]             fwd_data,
  input  logic                                  flush,
  input  logic                                  hold,
  output logic                                  stall_o,
  output logic                                  out_valid,
  output logic [CTRL_W-1:0]                     out_ctrl,
  output logic [ppu_pkg::REG_IDX_W-1:0]         out_rd,
  output logic [DATA_W-1:0]                     out_op_a,
  output logic [DATA_W-1:0]                     out_op_b
);
  import ppu_pkg::*;

  localparam int unsigned CNT_W = $clog2(STALL_CYCLES + 1);

  stage_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             haz;
  logic             load_bubble;
  logic             capture;
  logic [DATA_W-1:0] fwd_a, fwd_b;

  fwd_select #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W)) u_fwd_a (
    .rs       (in_rs1),
    .rf_data  (in_op_a),
    .fwd_we   (fwd_we),
    .fwd_rd   (fwd_rd),
    .fwd_data (fwd_data),
    .data     (fwd_a)
  );

  fwd_select #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W)) u_fwd_b (
    .rs       (in_rs2),
    .rf_data  (in_op_b),
    .fwd_we   (fwd_we),
    .fwd_rd   (fwd_rd),
    .fwd_data (fwd_data),
    .data     (fwd_b)
  );

  // Load in EX whose destination is read by the instruction in ID
  always_comb begin
    haz = in_valid && out_valid && out_ctrl[LOAD_BIT] && (out_rd != '0) &&
          ((out_rd == in_rs1) || (out_rd == in_rs2));
  end

  // Next state, stall output and datapath action, flush > hold > hazard
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    load_bubble = 1'b0;
    capture     = 1'b0;
    if (state == ST_RUN) begin
      stall_o = haz && !flush && !hold;
    end else begin
      stall_o = !flush;
    end

    if (flush) begin
      load_bubble = 1'b1;
      state_n     = ST_RUN;
      cnt_n       = '0;
    end else if (hold) begin
      state_n = state;
    end else if (state == ST_RUN) begin
      if (haz) begin
        load_bubble = 1'b1;
        // The hazard edge itself is the first bubble; STALL covers the rest
        if (STALL_CYCLES > 1) begin
          state_n = ST_STALL;
          cnt_n   = CNT_W'(STALL_CYCLES - 1);
        end
      end else begin
        capture = 1'b1;
      end
    end else begin
      load_bubble = 1'b1;
      cnt_n       = cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        state_n = ST_RUN;
      end
    end
  end

  // FSM state and bubble counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // EX-side registers: bubble, capture or retain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      out_rd    <= '0;
      out_op_a  <= '0;
      out_op_b  <= '0;
    end else if (load_bubble) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      out_rd    <= '0;
      out_op_a  <= '0;
      out_op_b  <= '0;
    end else if (capture) begin
      out_valid <= in_valid;
      out_ctrl  <= in_valid ? in_ctrl : '0;
      out_rd    <= in_rd;
      out_op_a  <= fwd_a;
      out_op_b  <= fwd_b;
    end
  end

endmodule
